// File: rtl/spi_frame_decoder_pkg.sv
// Shared types and constants for the SPI frame decoder.
// Optional feature macro: SPI_FRAME_CHK_EN (adds the check-byte state).
package spi_frame_pkg;

   // Opcode carried in bits [7:6] of every header byte
   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_TRIG  = 2'b11
   } opcode_t;

   // Frame parser states; the encoding is exported in the status byte
   typedef enum logic [1:0] {
      ST_HDR = 2'd0,
      ST_DAT = 2'd1
`ifdef SPI_FRAME_CHK_EN
      , ST_CHK = 2'd2
`endif
   } state_t;

   // Register bank addresses
   localparam logic [5:0] ADDR_DIN    = 6'h00;
   localparam logic [5:0] ADDR_WIN    = 6'h01;
   localparam logic [5:0] ADDR_BIAS   = 6'h02;
   localparam logic [5:0] ADDR_SIGN   = 6'h03;
   localparam logic [5:0] ADDR_RESULT = 6'h3F;

   // Key folded into the check byte of WRITE/TRIG frames
   localparam logic [7:0] CHK_KEY = 8'hA5;

   // Only the four bank registers accept writes
   function automatic logic addr_writable(input logic [5:0] a);
      return (a <= ADDR_SIGN);
   endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Bundles the SPI byte-stream side and the grid operand side of the decoder.
// Optional feature macro: SPI_FRAME_CHK_EN (no effect on this interface).
interface spi_frame_decoder_if;

   logic       ss;
   logic       spi_done;
   logic [7:0] spi_dout;
   logic [7:0] tx_data;
   logic [7:0] result;
   logic [7:0] din;
   logic [7:0] win;
   logic [7:0] bias;
   logic       sign;
   logic       trig;
   logic       busy;

   // Environment side: SPI slave and grid
   modport master (
      output ss, spi_done, spi_dout, result,
      input  tx_data, din, win, bias, sign, trig, busy
   );

   // Decoder side
   modport slave (
      input  ss, spi_done, spi_dout, result,
      output tx_data, din, win, bias, sign, trig, busy
   );

endinterface

// File: rtl/spi_frame_decoder_trig_pulse_gen.sv
// Fixed-width trigger pulse generator: a start request while idle produces a
// pulse of exactly TRIG_LEN cycles; starts while the pulse runs are dropped.
// Optional feature macro: SPI_FRAME_CHK_EN (no effect on this module).
module trig_pulse_gen
   import spi_frame_pkg::*;
#(
   parameter int TRIG_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic trig,
   output logic busy
);

   localparam int CW = $clog2(TRIG_LEN + 1);

   logic [CW-1:0] cnt;

   // Load on an idle start, then count down to zero; reset drops the pulse at once
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (start && (cnt == '0)) begin
         cnt <= CW'(TRIG_LEN);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign trig = (cnt != '0);
   assign busy = trig;

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI command frame decoder: parses header/payload(/check) bytes, owns the
// grid operand register bank, fires trigger pulses and returns readback or
// status bytes to the SPI shifter.
// Optional feature macro: SPI_FRAME_CHK_EN adds a check byte to WRITE and
// TRIG frames; without it those frames commit on their last data byte.
module spi_frame_decoder
   import spi_frame_pkg::*;
#(
   parameter int TRIG_LEN = 4,
   parameter int ERR_W    = 4
) (
   input logic                clk,
   input logic                rst,
   spi_frame_decoder_if.slave bus
);

   // Number of error-counter bits that fit in the status nibble
   localparam int ERR_SHOWN = (ERR_W < 4) ? ERR_W : 4;

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       addr;
   logic [ERR_W-1:0] err_cnt;
   logic [7:0]       rb;
   logic             rb_vld;
   logic [7:0]       rd_val;
   logic [7:0]       status;
   logic [7:0]       wdata;
   logic [7:0]       din;
   logic [7:0]       win;
   logic [7:0]       bias;
   logic             sign;
   logic             trig;
   logic             busy;

   opcode_t          op_in;
   logic             byte_vld;
   logic             hdr_ld;
   logic             wr_req;
   logic             trig_req;
   logic             rd_ld;
   logic             chk_err;
   logic             addr_ok;
   logic             wr_go;
   logic             trig_go;
   logic             err_inc;

`ifdef SPI_FRAME_CHK_EN
   logic [7:0]       hdr;
   logic [7:0]       pay;
   logic             pay_ld;
   logic [7:0]       chk_exp;
`endif

   // A byte only counts while a frame is open
   assign byte_vld = bus.spi_done & ~bus.ss;
   assign op_in    = opcode_t'(bus.spi_dout[7:6]);

`ifdef SPI_FRAME_CHK_EN
   // TRIG frames have no payload, so the check covers the header alone
   assign chk_exp = (opcode_t'(hdr[7:6]) == OP_WRITE) ? (hdr ^ pay ^ CHK_KEY)
                                                      : (hdr ^ CHK_KEY);
   assign wdata   = pay;
`else
   assign wdata   = bus.spi_dout;
`endif

   // Parser state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HDR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-byte action requests
   always_comb begin
      state_nxt = state;
      hdr_ld    = 1'b0;
      wr_req    = 1'b0;
      trig_req  = 1'b0;
      rd_ld     = 1'b0;
      chk_err   = 1'b0;
`ifdef SPI_FRAME_CHK_EN
      pay_ld    = 1'b0;
`endif
      if (bus.ss) begin
         // Deselect abandons any partial frame silently
         state_nxt = ST_HDR;
      end else if (bus.spi_done) begin
         case (state)
            ST_HDR: begin
               case (op_in)
                  OP_WRITE: begin
                     hdr_ld    = 1'b1;
                     state_nxt = ST_DAT;
                  end
                  OP_READ: begin
                     rd_ld = 1'b1;
                  end
                  OP_TRIG: begin
`ifdef SPI_FRAME_CHK_EN
                     hdr_ld    = 1'b1;
                     state_nxt = ST_CHK;
`else
                     trig_req  = 1'b1;
`endif
                  end
                  default: ;
               endcase
            end
            ST_DAT: begin
`ifdef SPI_FRAME_CHK_EN
               pay_ld    = 1'b1;
               state_nxt = ST_CHK;
`else
               wr_req    = 1'b1;
               state_nxt = ST_HDR;
`endif
            end
`ifdef SPI_FRAME_CHK_EN
            ST_CHK: begin
               state_nxt = ST_HDR;
               if (bus.spi_dout == chk_exp) begin
                  if (opcode_t'(hdr[7:6]) == OP_WRITE) begin
                     wr_req = 1'b1;
                  end else begin
                     trig_req = 1'b1;
                  end
               end else begin
                  chk_err = 1'b1;
               end
            end
`endif
            default: begin
               state_nxt = ST_HDR;
            end
         endcase
      end
   end

   // Commit qualification: bad address or retrigger become errors instead
   assign addr_ok = addr_writable(addr);
   assign wr_go   = wr_req & addr_ok;
   assign trig_go = trig_req & ~busy;
   assign err_inc = chk_err | (wr_req & ~addr_ok) | (trig_req & busy);

   // Frame capture registers (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (hdr_ld) begin
         addr <= bus.spi_dout[5:0];
`ifdef SPI_FRAME_CHK_EN
         hdr  <= bus.spi_dout;
`endif
      end
`ifdef SPI_FRAME_CHK_EN
      if (pay_ld) begin
         pay <= bus.spi_dout;
      end
`endif
   end

   // Grid operand register bank
   always_ff @(posedge clk) begin
      if (rst) begin
         din  <= '0;
         win  <= '0;
         bias <= '0;
         sign <= 1'b0;
      end else if (wr_go) begin
         case (addr)
            ADDR_DIN:  din  <= wdata;
            ADDR_WIN:  win  <= wdata;
            ADDR_BIAS: bias <= wdata;
            ADDR_SIGN: sign <= wdata[0];
            default: ;
         endcase
      end
   end

   // Readback mux addressed directly by the READ header byte
   always_comb begin
      case (bus.spi_dout[5:0])
         ADDR_DIN:    rd_val = din;
         ADDR_WIN:    rd_val = win;
         ADDR_BIAS:   rd_val = bias;
         ADDR_SIGN:   rd_val = {7'b0, sign};
         ADDR_RESULT: rd_val = bus.result;
         default:     rd_val = 8'hFF;
      endcase
   end

   // Readback byte is held until the next accepted byte
   always_ff @(posedge clk) begin
      if (rst) begin
         rb_vld <= 1'b0;
      end else if (byte_vld) begin
         rb_vld <= rd_ld;
      end
   end

   // Readback data capture
   always_ff @(posedge clk) begin
      if (rd_ld) begin
         rb <= rd_val;
      end
   end

   // Saturating frame-error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_inc && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

   // Status byte: {state, busy, 0, low error-count nibble}
   always_comb begin
      status                  = {state, busy, 1'b0, 4'h0};
      status[ERR_SHOWN-1:0]   = err_cnt[ERR_SHOWN-1:0];
   end

   trig_pulse_gen #(
      .TRIG_LEN (TRIG_LEN)
   ) u_trig (
      .clk   (clk),
      .rst   (rst),
      .start (trig_go),
      .trig  (trig),
      .busy  (busy)
   );

   assign bus.tx_data = rb_vld ? rb : status;
   assign bus.din     = din;
   assign bus.win     = win;
   assign bus.bias    = bias;
   assign bus.sign    = sign;
   assign bus.trig    = trig;
   assign bus.busy    = busy;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Scoreboard bench for spi_frame_decoder: stimulus schedules expected output
// values against clock-edge numbers, a monitor pops and compares them.
// Optional feature macro: SPI_FRAME_CHK_EN (frames gain check bytes).
module tb_spi_frame_decoder;

   localparam int TRIG_LEN = 4;

   typedef enum {S_DIN, S_WIN, S_BIAS, S_SIGN, S_TRIG, S_BUSY, S_TX} sel_t;
   typedef struct {
      int         due;
      sel_t       sel;
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_frame_decoder_if bus ();

   spi_frame_decoder #(
      .TRIG_LEN (TRIG_LEN),
      .ERR_W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   last_e  = 0;
   int   err_exp = 0;
   logic [7:0] din_exp = 8'h00;

   function automatic logic [7:0] sample(input sel_t s);
      case (s)
         S_DIN:   return bus.din;
         S_WIN:   return bus.win;
         S_BIAS:  return bus.bias;
         S_SIGN:  return {7'b0, bus.sign};
         S_TRIG:  return {7'b0, bus.trig};
         S_BUSY:  return {7'b0, bus.busy};
         default: return bus.tx_data;
      endcase
   endfunction

   // Idle-state status byte for the current expected error count
   function automatic logic [7:0] st_idle();
      int e;
      e = (err_exp > 15) ? 15 : err_exp;
      return {4'b0000, 4'(e)};
   endfunction

   // Insert keeping the queue ordered by due edge
   task automatic expect_at(input int due, input sel_t s, input logic [7:0] v, input string nm);
      exp_t it;
      int   i;
      it.due  = due;
      it.sel  = s;
      it.exp  = v;
      it.name = nm;
      i = 0;
      while (i < q.size() && q[i].due <= due) i++;
      q.insert(i, it);
   endtask

   // Monitor: checks every expectation due at this edge, 1ns after it
   initial begin
      exp_t       it;
      logic [7:0] act;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            it  = q.pop_front();
            act = sample(it.sel);
            n_tests++;
            if (it.due < cyc || act !== it.exp) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h (edge %0d, due %0d)",
                        it.name, act, it.exp, cyc, it.due);
            end
         end
      end
   end

   // One byte strobe per call, with an idle cycle before it; last_e = sampling edge
   task automatic drive_byte(input logic [7:0] b);
      @(negedge clk);
      bus.spi_done = 1'b0;
      @(negedge clk);
      bus.spi_dout = b;
      bus.spi_done = 1'b1;
      last_e       = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.spi_done = 1'b0;
      end
   endtask

   task automatic write_frame(input logic [7:0] h, input logic [7:0] d);
      drive_byte(h);
      drive_byte(d);
`ifdef SPI_FRAME_CHK_EN
      drive_byte(h ^ d ^ 8'hA5);
`endif
   endtask

   task automatic trig_frame();
      drive_byte(8'hC0);
`ifdef SPI_FRAME_CHK_EN
      drive_byte(8'hC0 ^ 8'hA5);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d expected empty", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int e2;
      int guard;
      bus.ss       = 1'b1;
      bus.spi_done = 1'b0;
      bus.spi_dout = 8'h00;
      bus.result   = 8'h00;

      // Reset then idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(10);
      n_tests++;
      if (bus.din !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_din: got %h, expected 00", bus.din);
      end
      n_tests++;
      if (bus.win !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_win: got %h, expected 00", bus.win);
      end
      n_tests++;
      if (bus.bias !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_bias: got %h, expected 00", bus.bias);
      end
      n_tests++;
      if (bus.trig !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_trig: got %b, expected 0", bus.trig);
      end
      n_tests++;
      if (bus.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_tx: got %h, expected 00", bus.tx_data);
      end
      expect_at(cyc + 1, S_DIN,  8'h00, "rst_din");
      expect_at(cyc + 1, S_WIN,  8'h00, "rst_win");
      expect_at(cyc + 1, S_BIAS, 8'h00, "rst_bias");
      expect_at(cyc + 1, S_SIGN, 8'h00, "rst_sign");
      expect_at(cyc + 1, S_TRIG, 8'h00, "rst_trig");
      expect_at(cyc + 1, S_BUSY, 8'h00, "rst_busy");
      expect_at(cyc + 1, S_TX,   8'h00, "rst_tx");
      idle(2);
      bus.ss = 1'b0;

      // WRITE win
      drive_byte(8'h41);
      expect_at(last_e, S_WIN, 8'h00, "wr_win_early");
      expect_at(last_e, S_TX,  8'h40, "status_in_dat");
      drive_byte(8'h5A);
`ifdef SPI_FRAME_CHK_EN
      drive_byte(8'h41 ^ 8'h5A ^ 8'hA5);
`endif
      expect_at(last_e, S_WIN,  8'h5A, "wr_win");
      expect_at(last_e, S_DIN,  8'h00, "wr_win_din_kept");
      expect_at(last_e, S_BIAS, 8'h00, "wr_win_bias_kept");
      expect_at(last_e, S_TX,   8'h00, "wr_win_status");

      // TRIG pulse width, then a retrigger during the pulse
      trig_frame();
      t = last_e;
      for (int k = 0; k < TRIG_LEN; k++) expect_at(t + k, S_TRIG, 8'h01, "trig_high");
      expect_at(t + TRIG_LEN, S_TRIG, 8'h00, "trig_end");
      expect_at(t, S_BUSY, 8'h01, "busy_high");
      expect_at(t + TRIG_LEN, S_BUSY, 8'h00, "busy_end");
      expect_at(t, S_TX, 8'h20, "status_busy");
      trig_frame();
      e2 = last_e;
      err_exp++;
      expect_at(e2, S_TX, (e2 < t + TRIG_LEN) ? 8'h21 : 8'h01, "retrig_err");
      expect_at(t + TRIG_LEN + 1, S_TRIG, 8'h00, "retrig_no_extend");
      idle(8);

      // READ result, held until the next byte, then status
      bus.result = 8'h37;
      drive_byte(8'hBF);
      t = last_e;
      expect_at(t,     S_TX, 8'h37, "rd_result");
      expect_at(t + 1, S_TX, 8'h37, "rd_hold1");
      expect_at(t + 3, S_TX, 8'h37, "rd_hold3");
      idle(1);
      bus.result = 8'h99;
      idle(2);
      drive_byte(8'h00);
      expect_at(last_e, S_TX, st_idle(), "rd_revert");
      drive_byte(8'h81);
      expect_at(last_e, S_TX, 8'h5A, "rd_win");
      drive_byte(8'h84);
      expect_at(last_e, S_TX, 8'hFF, "rd_invalid");
      drive_byte(8'h83);
      expect_at(last_e, S_TX, 8'h00, "rd_sign0");

      // Deselect mid-frame, ignored strobes while deselected
      drive_byte(8'h42);
      @(negedge clk);
      bus.spi_done = 1'b0;
      bus.ss       = 1'b1;
      expect_at(cyc + 1, S_TX, st_idle(), "ss_abort_status");
      drive_byte(8'h40);
      drive_byte(8'hEE);
      expect_at(last_e, S_DIN, 8'h00, "ss_high_ignored");
      @(negedge clk);
      bus.spi_done = 1'b0;
      bus.ss       = 1'b0;
      write_frame(8'h40, 8'h11);
      din_exp = 8'h11;
      expect_at(last_e, S_DIN,  din_exp, "ss_then_din");
      expect_at(last_e, S_BIAS, 8'h00,   "ss_bias_kept");
      expect_at(last_e, S_TX,   st_idle(), "ss_no_err");

`ifdef SPI_FRAME_CHK_EN
      // Check-byte mismatch and match
      drive_byte(8'h40);
      drive_byte(8'h22);
      drive_byte(8'h00);
      err_exp++;
      expect_at(last_e, S_DIN, din_exp,   "chk_bad_din");
      expect_at(last_e, S_TX,  st_idle(), "chk_bad_err");
      drive_byte(8'h40);
      drive_byte(8'h22);
      drive_byte(8'hC7);
      din_exp = 8'h22;
      expect_at(last_e, S_DIN, din_exp,   "chk_good_din");
      expect_at(last_e, S_TX,  st_idle(), "chk_good_status");
      drive_byte(8'hC0);
      drive_byte(8'h00);
      err_exp++;
      expect_at(last_e,     S_TRIG, 8'h00, "chk_bad_trig");
      expect_at(last_e + 1, S_TRIG, 8'h00, "chk_bad_trig2");
      expect_at(last_e,     S_TX,   st_idle(), "chk_bad_trig_err");
`endif

      // Invalid address, reg 3 masking
      write_frame(8'h44, 8'h99);
      err_exp++;
      expect_at(last_e, S_DIN, din_exp,   "bad_addr_din");
      expect_at(last_e, S_TX,  st_idle(), "bad_addr_err");
      write_frame(8'h43, 8'hFF);
      expect_at(last_e, S_SIGN, 8'h01, "wr_sign");
      drive_byte(8'h83);
      expect_at(last_e, S_TX, 8'h01, "rd_sign_masked");

      // Error counter saturation
      while (err_exp < 14) begin
         write_frame(8'h45, 8'h00);
         err_exp++;
      end
      write_frame(8'h7F, 8'h00);
      err_exp++;
      expect_at(last_e, S_TX, 8'h0F, "err_full");
      write_frame(8'h46, 8'h00);
      err_exp++;
      expect_at(last_e, S_TX, 8'h0F, "err_saturated");

      // Reset in the middle of a pulse
      trig_frame();
      t = last_e;
      expect_at(t,     S_TRIG, 8'h01, "pre_rst_trig");
      expect_at(t + 1, S_TRIG, 8'h01, "pre_rst_trig2");
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      expect_at(cyc + 1, S_TRIG, 8'h00, "rst_mid_trig");
      expect_at(cyc + 1, S_BUSY, 8'h00, "rst_mid_busy");
      expect_at(cyc + 1, S_DIN,  8'h00, "rst_mid_din");
      expect_at(cyc + 1, S_SIGN, 8'h00, "rst_mid_sign");
      expect_at(cyc + 1, S_TX,   8'h00, "rst_mid_tx");
      @(negedge clk);
      rst = 1'b0;
      idle(5);
      n_tests++;
      if (bus.trig !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst_trig: got trig=%b busy=%b, expected 0/0", bus.trig, bus.busy);
      end
      n_tests++;
      if (bus.din !== 8'h00) begin
         n_fail++;
         $display("FAIL post_rst_din: got %h, expected 00", bus.din);
      end
      n_tests++;
      if (bus.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL post_rst_tx: got %h, expected 00", bus.tx_data);
      end

      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      while (q.size() > 0) begin
         exp_t it;
         it = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: never checked, expected %h by edge %0d", it.name, it.exp, it.due);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
